// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier, WIDTH-bit signed/unsigned operands.
// Valid/ready on operands and product; one operation in flight.
module seq_mult_hs #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               signed_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] ms;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   r;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               term;

  // Magnitude of the most negative value wraps to 2^(W-1) unsigned.
  always_comb begin
    a_abs = (signed_in && a_in[WIDTH-1]) ? -a_in : a_in;
    b_abs = (signed_in && b_in[WIDTH-1]) ? -b_in : b_in;
    term  = (EARLY_TERM && (r == '0)) || (cnt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ms        <= '0;
      p         <= '0;
      r         <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ms       <= {{WIDTH{1'b0}}, a_abs};
            r        <= b_abs;
            p        <= '0;
            cnt      <= CW'(WIDTH);
            neg      <= signed_in & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (term) begin
            state <= FIXUP;
          end else begin
            p   <= p + (r[0] ? ms : '0);
            ms  <= ms << 1;
            r   <= r >> 1;
            cnt <= cnt - 1'b1;
          end
        end
        FIXUP: begin
          product   <= neg ? -p : p;
          state     <= DONE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Self-checking bench for seq_mult_hs: 8-bit early-term and
// 4-bit fixed-length instances against an arithmetic model.
module tb_seq_mult_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel4;
  logic       iv, ordy, sgn;
  logic [7:0] av, bv;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [15:0] product8;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [7:0]  product4;

  logic        rdy, ov, bsy;
  logic [15:0] prod;

  assign in_valid8  = iv & ~sel4;
  assign out_ready8 = ordy & ~sel4;
  assign in_valid4  = iv & sel4;
  assign out_ready4 = ordy & sel4;
  assign rdy  = sel4 ? in_ready4 : in_ready8;
  assign ov   = sel4 ? out_valid4 : out_valid8;
  assign bsy  = sel4 ? busy4 : busy8;
  assign prod = sel4 ? {8'h00, product4} : product8;

  seq_mult_hs #(.WIDTH(8), .EARLY_TERM(1'b1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a_in(av), .b_in(bv), .signed_in(sgn),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .product(product8), .busy(busy8)
  );

  seq_mult_hs #(.WIDTH(4), .EARLY_TERM(1'b0)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a_in(av[3:0]), .b_in(bv[3:0]), .signed_in(sgn),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .product(product4), .busy(busy4)
  );

  int passed = 0;
  int total  = 0;

  // Reference: exact integer product truncated to 2W bits.
  function automatic logic [15:0] ref_prod(int w, int a, int b, bit s);
    longint x, y, m;
    x = a;
    y = b;
    if (s) begin
      if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
      if (y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    end
    m = (x * y) & ((longint'(1) << (2 * w)) - 1);
    return m[15:0];
  endfunction

  // Number of shift-add steps: bit length of |b|, or WIDTH.
  function automatic int ref_steps(int w, bit et, int b, bit s);
    int mag, n;
    if (!et) return w;
    mag = b;
    if (s && b >= (1 << (w - 1))) mag = (1 << w) - b;
    n = 0;
    while (mag > 0) begin
      mag = mag >> 1;
      n++;
    end
    return n;
  endfunction

  task automatic run_op(input int w, input logic [7:0] a,
                        input logic [7:0] b, input logic s,
                        input logic [15:0] ep, input int el,
                        input string name);
    int lat;
    int waitc;
    bit busy_ok;
    sel4 = (w == 4);
    waitc = 0;
    @(negedge clk);
    while (!rdy && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    total++;
    if (rdy !== 1'b1)
      $display("FAIL %s accept: in_ready=%b required 1", name, rdy);
    else passed++;
    av = a; bv = b; sgn = s; iv = 1'b1; ordy = 1'b0;
    @(posedge clk);
    #1;
    iv = 1'b0;
    av = 8'($urandom); bv = 8'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (ov !== 1'b1 && lat < 100) begin
      if (bsy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat != el)
      $display("FAIL %s latency: got %0d required %0d", name, lat, el);
    else passed++;
    total++;
    if (prod !== ep)
      $display("FAIL %s product: got %h required %h", name, prod, ep);
    else passed++;
    total++;
    if (!busy_ok)
      $display("FAIL %s busy: dropped low before out_valid, required 1", name);
    else passed++;
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
    total++;
    if (rdy !== 1'b1 || ov !== 1'b0 || prod !== ep)
      $display("FAIL %s release: in_ready=%b out_valid=%b product=%h required 1 0 %h",
               name, rdy, ov, prod, ep);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    total++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 ||
        busy8 !== 1'b0 || product8 !== 16'h0)
      $display("FAIL reset8: rdy=%b ov=%b busy=%b prod=%h required 1 0 0 0000",
               in_ready8, out_valid8, busy8, product8);
    else passed++;
    total++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 ||
        busy4 !== 1'b0 || product4 !== 8'h0)
      $display("FAIL reset4: rdy=%b ov=%b busy=%b prod=%h required 1 0 0 00",
               in_ready4, out_valid4, busy4, product4);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed8();
    run_op(8, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 10, "u255x255");
    run_op(8, 8'h80, 8'h80, 1'b1, 16'h4000, 10, "s-128x-128");
    run_op(8, 8'hFD, 8'h05, 1'b1, 16'hFFF1, 5, "s-3x5");
    run_op(8, 8'h7F, 8'hFF, 1'b1, 16'hFF81, 3, "s127x-1");
    run_op(8, 8'h80, 8'h02, 1'b0, 16'h0100, 4, "u80x02");
  endtask

  task automatic test_early_term();
    run_op(8, 8'h5A, 8'h00, 1'b0, 16'h0000, 2, "b_zero");
    run_op(8, 8'd200, 8'h01, 1'b0, 16'd200, 3, "b_one");
    run_op(8, 8'h00, 8'h40, 1'b0, 16'h0000, 9, "a_zero");
  endtask

  task automatic test_backpressure();
    int waitc;
    sel4 = 1'b0;
    @(negedge clk);
    av = 8'd25; bv = 8'd10; sgn = 1'b0; iv = 1'b1; ordy = 1'b0;
    @(posedge clk);
    #1;
    iv = 1'b0;
    waitc = 0;
    while (out_valid8 !== 1'b1 && waitc < 100) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    total++;
    if (out_valid8 !== 1'b1)
      $display("FAIL bp_done: out_valid=%b required 1", out_valid8);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv = ~iv;
      av = 8'($urandom); bv = 8'($urandom);
      @(posedge clk);
      #1;
      total++;
      if (product8 !== 16'd250 || out_valid8 !== 1'b1 || in_ready8 !== 1'b0)
        $display("FAIL bp_hold%0d: prod=%h ov=%b rdy=%b required 00fa 1 0",
                 i, product8, out_valid8, in_ready8);
      else passed++;
    end
    @(negedge clk);
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
    total++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || product8 !== 16'd250)
      $display("FAIL bp_release: rdy=%b ov=%b prod=%h required 1 0 00fa",
               in_ready8, out_valid8, product8);
    else passed++;
    run_op(8, 8'd12, 8'd12, 1'b0, 16'd144, 6, "bp_next12x12");
  endtask

  task automatic test_reset_mid_run();
    sel4 = 1'b0;
    @(negedge clk);
    av = 8'd100; bv = 8'hFF; sgn = 1'b0; iv = 1'b1; ordy = 1'b0;
    @(posedge clk);
    #1;
    iv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid8 !== 1'b0 || product8 !== 16'h0 ||
        in_ready8 !== 1'b1 || busy8 !== 1'b0)
      $display("FAIL mid_reset: ov=%b prod=%h rdy=%b busy=%b required 0 0000 1 0",
               out_valid8, product8, in_ready8, busy8);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    run_op(8, 8'd7, 8'd9, 1'b0, 16'd63, 6, "after_reset7x9");
  endtask

  task automatic test_width4();
    run_op(4, 8'h0F, 8'h0F, 1'b0, 16'h00E1, 6, "w4_u15x15");
    run_op(4, 8'h08, 8'h07, 1'b1, 16'h00C8, 6, "w4_s-8x7");
    run_op(4, 8'h01, 8'h01, 1'b1, 16'h0001, 6, "w4_s1x1");
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic        s;
    logic [15:0] ep;
    int          el;
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom);
      s = 1'($urandom);
      ep = ref_prod(8, int'(a), int'(b), s);
      el = ref_steps(8, 1'b1, int'(b), s) + 2;
      run_op(8, a, b, s, ep, el, $sformatf("rand8_%0d", i));
    end
    for (int i = 0; i < 15; i++) begin
      a = {4'h0, 4'($urandom)};
      b = {4'h0, 4'($urandom)};
      s = 1'($urandom);
      ep = ref_prod(4, int'(a), int'(b), s);
      el = ref_steps(4, 1'b0, int'(b), s) + 2;
      run_op(4, a, b, s, ep, el, $sformatf("rand4_%0d", i));
    end
  endtask

  initial begin
    sel4 = 1'b0;
    iv = 1'b0; ordy = 1'b0; sgn = 1'b0;
    av = 8'h0; bv = 8'h0;
    #1;
    test_reset();
    test_directed8();
    test_early_term();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
